load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and memory bus bundle for the load/store unit.
//
// Handshake: the requester presents req_valid with its fields for one cycle.
// The unit takes it only while busy is low; anything offered while busy is
// high is dropped, so the requester must watch busy. Completion is a single
// done (or error) pulse. On the memory side the unit holds its strobe and
// fields steady until it samples mem_resp high.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport slave (
        input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output busy, done, load_data, error,
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );

    modport master (
        output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  busy, done, load_data, error,
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes one load or store at a time, runs a single memory
// access, then extends load data and pulses done. Bad requests pulse error
// without touching memory. done, error and load_data are registered, so done
// appears the cycle after RESP, when busy has already dropped.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output logic [1:0]       fsm_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        is_read_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data_q;
    logic [31:0] tcount;
    logic        done_q;
    logic        error_q;

    logic        one_op;
    logic        both_op;
    logic        size_half;
    logic        size_word;
    logic        misaligned;
    logic        illegal;
    logic        accept;
    logic        reject;
    logic        timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Classify the incoming request and the access timeout
    always_comb begin
        one_op     = bus.req_read ^ bus.req_write;
        both_op    = bus.req_read & bus.req_write;
        size_half  = (bus.req_funct3[1:0] == 2'b01);
        size_word  = (bus.req_funct3[1:0] == 2'b10);
        misaligned = (size_half && bus.req_addr[0]) ||
                     (size_word && (bus.req_addr[1:0] != 2'b00));
        if (bus.req_read) begin
            illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                      (bus.req_funct3 == 3'd7);
        end else begin
            illegal = (bus.req_funct3 >= 3'd3);
        end
        accept      = (state == IDLE) && bus.req_valid && one_op && !misaligned && !illegal;
        reject      = (state == IDLE) && bus.req_valid &&
                      (both_op || (one_op && (misaligned || illegal)));
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tcount == TIMEOUT_CYCLES - 1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a response in the same cycle as the timeout wins
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS: begin
                if (bus.mem_resp) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select and extend the captured read word for the registered load type
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_ext = {24'd0, byte_sel};
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd5:    load_ext = {16'd0, half_sel};
            default: load_ext = rdata_q;
        endcase
    end

    // Request capture, read capture, timeout count and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            is_read_q   <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            tcount      <= 32'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            if (accept) begin
                is_read_q <= bus.req_read;
                funct3_q  <= bus.req_funct3;
                addr_q    <= bus.req_addr;
                wdata_q   <= bus.req_wdata;
            end
            if ((state == ACCESS) && bus.mem_resp) begin
                rdata_q <= bus.mem_rdata;
            end
            tcount  <= ((state == ACCESS) && !bus.mem_resp) ? tcount + 32'd1 : 32'd0;
            done_q  <= (state == RESP);
            if (state == RESP) begin
                load_data_q <= load_ext;
            end
            error_q <= reject || ((state == ACCESS) && !bus.mem_resp && timeout_hit);
        end
    end

    // Outputs: strobes and lane-shifted store fields only while in ACCESS
    always_comb begin
        bus.busy            = (state != IDLE);
        bus.done            = done_q;
        bus.error           = error_q;
        bus.load_data       = load_data_q;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 32'd0;
        bus.mem_byte_enable = 4'd0;
        bus.mem_wdata       = 32'd0;
        fsm_state           = state;
        if (state == ACCESS) begin
            bus.mem_read    = is_read_q;
            bus.mem_write   = !is_read_q;
            bus.mem_address = {addr_q[31:2], 2'b00};
            if (!is_read_q) begin
                case (funct3_q[1:0])
                    2'b00: begin
                        bus.mem_byte_enable = 4'b0001 << addr_q[1:0];
                        bus.mem_wdata       = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        bus.mem_byte_enable = 4'b0011 << addr_q[1:0];
                        bus.mem_wdata       = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        bus.mem_byte_enable = 4'b1111;
                        bus.mem_wdata       = wdata_q;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-cycle expectation timeline built
// from the access rules, a load-result queue, and literal spot checks.
module tb_load_store_unit;
    localparam int NCYC = 1024;
    localparam int TMO  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fsm_state;
    int         cyc = 0;
    logic       cmp_en = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, indexed by cycle number
    logic        exp_busy  [NCYC];
    logic        exp_done  [NCYC];
    logic        exp_err   [NCYC];
    logic        exp_rd    [NCYC];
    logic        exp_wr    [NCYC];
    logic        exp_ldchk [NCYC];
    logic [31:0] exp_addr  [NCYC];
    logic [31:0] exp_wdata [NCYC];
    logic [3:0]  exp_be    [NCYC];
    logic [31:0] exp_q[$];

    // Per-transaction observations
    int          lat;
    logic        saw_rd, saw_wr, saw_err, saw_done, busy_at_lat;
    logic [31:0] ld_at_lat, acc_addr, acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_wr;
    logic        rst_rd, rst_busy, rst_done;

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Model: what a request presented in cycle n must produce
    task automatic model_txn(input int n, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int delay, input int rst_k);
        int          size;
        int          off;
        int          last;
        logic        sgn;
        logic        bad;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] sh;
        logic [31:0] ld;
        size = 0;
        sgn  = 1'b0;
        if (!rd && !wr) return;
        if (rd && !wr) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd4: size = 1;
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd5: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end else if (wr && !rd) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end
        if (size == 0) bad = 1'b1;
        else           bad = ((addr % size) != 0);
        if (bad) begin
            exp_err[n + 1] = 1'b1;
            return;
        end
        off  = int'(addr % 4);
        be   = 4'(((1 << size) - 1) << off);
        if (size == 1)      wd = (wdata & 32'hFF) * 32'h0101_0101;
        else if (size == 2) wd = (wdata & 32'hFFFF) * 32'h0001_0001;
        else                wd = wdata;
        last = (delay > 0) ? n + delay : n + TMO;
        if (rst_k >= 0) last = n + rst_k;
        for (int c = n + 1; c <= last; c++) begin
            exp_busy[c] = 1'b1;
            exp_rd[c]   = rd;
            exp_wr[c]   = wr;
            exp_addr[c] = addr - 32'(off);
            if (wr) begin
                exp_be[c]    = be;
                exp_wdata[c] = wd;
            end
        end
        if (rst_k >= 0) return;
        if (delay > 0) begin
            exp_busy[n + delay + 1]  = 1'b1;
            exp_done[n + delay + 2]  = 1'b1;
            exp_ldchk[n + delay + 2] = rd;
            if (rd) begin
                sh = rdata >> (8 * off);
                if (size == 1) begin
                    ld = sh & 32'hFF;
                    if (sgn && ld[7]) ld = ld | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    ld = sh & 32'hFFFF;
                    if (sgn && ld[15]) ld = ld | 32'hFFFF_0000;
                end else begin
                    ld = rdata;
                end
                exp_q.push_back(ld);
            end
        end else begin
            exp_err[n + TMO + 1] = 1'b1;
        end
    endtask

    // Scoreboard: every cycle after reset, compare outputs with the timeline
    always @(negedge clk) begin
        if (cmp_en && cyc < NCYC) begin
            check1("busy", bus.busy, exp_busy[cyc]);
            check1("done", bus.done, exp_done[cyc]);
            check1("error", bus.error, exp_err[cyc]);
            check1("mem_read", bus.mem_read, exp_rd[cyc]);
            check1("mem_write", bus.mem_write, exp_wr[cyc]);
            check32("mem_address", bus.mem_address, exp_addr[cyc]);
            check32("mem_byte_enable", {28'd0, bus.mem_byte_enable}, {28'd0, exp_be[cyc]});
            check32("mem_wdata", bus.mem_wdata, exp_wdata[cyc]);
            if (exp_ldchk[cyc]) begin
                if (exp_q.size() == 0) begin
                    check32("load_queue_empty", 32'd1, 32'd0);
                end else begin
                    check32("load_data", bus.load_data, exp_q.pop_front());
                end
            end
        end
    end

    // Driver: present one request in the current cycle, answer memory after
    // `delay` cycles (0 = never), optionally offer intruder requests while
    // busy, optionally pulse rst rst_k cycles after acceptance
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay,
                         input logic inject, input int rst_k);
        int limit;
        model_txn(cyc, rd, wr, f3, addr, wdata, rdata, delay, rst_k);
        lat = -1;
        saw_rd = 1'b0; saw_wr = 1'b0; saw_err = 1'b0; saw_done = 1'b0;
        busy_at_lat = 1'b0; ld_at_lat = 32'd0;
        rst_rd = 1'b1; rst_busy = 1'b1; rst_done = 1'b1;
        limit = (delay > 0) ? delay + 4 : 12;
        for (int k = 0; k < limit; k++) begin
            if (k == 0) begin
                bus.req_valid = 1'b1; bus.req_read = rd; bus.req_write = wr;
                bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
            end else if (inject && k <= delay + 1) begin
                bus.req_valid = 1'b1;
                bus.req_read  = k[0] ? 1'b0 : 1'b1;
                bus.req_write = k[0] ? 1'b1 : 1'b0;
                bus.req_funct3 = 3'd2;
                bus.req_addr  = k[0] ? 32'h0000_0FFC : 32'h0000_0001;
                bus.req_wdata = 32'h5555_5555;
            end else begin
                bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
            end
            bus.mem_resp  = (delay > 0) && (k == delay);
            bus.mem_rdata = ((delay > 0) && (k == delay)) ? rdata : 32'h0BAD_0BAD;
            rst = (rst_k >= 0) && (k == rst_k);
            @(negedge clk);
            if (k == 1) begin
                acc_addr = bus.mem_address; acc_be = bus.mem_byte_enable;
                acc_wdata = bus.mem_wdata; acc_wr = bus.mem_write;
            end
            if (bus.mem_read)  saw_rd = 1'b1;
            if (bus.mem_write && k > 1 && inject) saw_wr = 1'b1;
            if (bus.error)     saw_err = 1'b1;
            if (bus.done)      saw_done = 1'b1;
            if ((bus.done || bus.error) && lat < 0) begin
                lat = k; busy_at_lat = bus.busy; ld_at_lat = bus.load_data;
            end
            if (rst_k >= 0 && k == rst_k + 1) begin
                rst_rd = bus.mem_read; rst_busy = bus.busy; rst_done = bus.done;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
        bus.mem_resp = 1'b0; rst = 1'b0;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Stimulus
    initial begin
        for (int c = 0; c < NCYC; c++) begin
            exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_err[c] = 1'b0;
            exp_rd[c] = 1'b0; exp_wr[c] = 1'b0; exp_ldchk[c] = 1'b0;
            exp_addr[c] = 32'd0; exp_wdata[c] = 32'd0; exp_be[c] = 4'd0;
        end
        bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
        bus.req_funct3 = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.mem_rdata = 32'd0; bus.mem_resp = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_done", bus.done, 1'b0);
        check1("rst_error", bus.error, 1'b0);
        check1("rst_mem_read", bus.mem_read, 1'b0);
        check1("rst_mem_write", bus.mem_write, 1'b0);
        check32("rst_mem_address", bus.mem_address, 32'd0);
        check32("rst_mem_byte_enable", {28'd0, bus.mem_byte_enable}, 32'd0);
        check32("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check32("rst_load_data", bus.load_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // lw, response on the second ACCESS cycle
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 2, 1'b0, -1);
        check32("lw_latency", 32'(lat), 32'd4);
        check32("lw_data", ld_at_lat, 32'hDEAD_BEEF);
        check32("lw_address", acc_addr, 32'h0000_0100);

        // lb / lbu on the top byte
        issue(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1, 1'b0, -1);
        check32("lb_latency", 32'(lat), 32'd3);
        check32("lb_data", ld_at_lat, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1, 1'b0, -1);
        check32("lbu_data", ld_at_lat, 32'h0000_0080);

        // sh to the upper halfword
        issue(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'd0, 1, 1'b0, -1);
        check32("sh_be", {28'd0, acc_be}, 32'h0000_000C);
        check32("sh_wdata", acc_wdata, 32'hABCD_ABCD);
        check1("sh_write", acc_wr, 1'b1);
        check32("sh_address", acc_addr, 32'h0000_0200);

        // Misaligned lw
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 1, 1'b0, -1);
        check32("misalign_latency", 32'(lat), 32'd1);
        check1("misalign_no_read", saw_rd, 1'b0);
        check1("misalign_no_done", saw_done, 1'b0);
        check1("misalign_busy", busy_at_lat, 1'b0);

        // Further lane patterns
        issue(1'b0, 1'b1, 3'd0, 32'h0000_0201, 32'h0000_00A5, 32'd0, 3, 1'b0, -1);
        issue(1'b0, 1'b1, 3'd2, 32'h0000_0204, 32'hCAFE_F00D, 32'd0, 1, 1'b0, -1);
        issue(1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'd0, 32'h8001_1234, 1, 1'b0, -1);
        check32("lh_data", ld_at_lat, 32'hFFFF_8001);
        issue(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'd0, 32'h8001_1234, 1, 1'b0, -1);
        check32("lhu_data", ld_at_lat, 32'h0000_8001);
        issue(1'b1, 1'b0, 3'd1, 32'h0000_0100, 32'd0, 32'h8001_F234, 2, 1'b0, -1);

        // Illegal and conflicting requests
        issue(1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'd0, 32'd0, 1, 1'b0, -1);
        issue(1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'd0, 32'd0, 1, 1'b0, -1);
        issue(1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'd0, 32'd0, 1, 1'b0, -1);
        check1("both_error", saw_err, 1'b1);
        issue(1'b0, 1'b1, 3'd1, 32'h0000_0203, 32'd0, 32'd0, 1, 1'b0, -1);

        // Valid without read or write, with mem_resp while idle: no effect
        issue(1'b0, 1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, -1);
        check32("idle_resp_no_event", 32'(lat), 32'hFFFF_FFFF);

        // Timeout: no memory response
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'd0, 0, 1'b0, -1);
        check32("timeout_latency", 32'(lat), 32'(TMO + 1));
        check1("timeout_busy", busy_at_lat, 1'b0);
        check1("timeout_no_done", saw_done, 1'b0);

        // Requests offered while busy are dropped
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'd0, 32'h1357_9BDF, 3, 1'b1, -1);
        check32("busy_drop_data", ld_at_lat, 32'h1357_9BDF);
        check1("busy_drop_no_write", saw_wr, 1'b0);
        check1("busy_drop_no_error", saw_err, 1'b0);

        // Reset in the middle of ACCESS
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'd0, 32'd0, 0, 1'b0, 2);
        check1("rst_access_mem_read", rst_rd, 1'b0);
        check1("rst_access_busy", rst_busy, 1'b0);
        check1("rst_access_done", rst_done, 1'b0);
        check32("rst_access_no_event", 32'(lat), 32'hFFFF_FFFF);

        // Recovery after reset
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'd0, 32'h0123_4567, 1, 1'b0, -1);
        check32("recover_data", ld_at_lat, 32'h0123_4567);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("load_queue_drained", 32'(exp_q.size()), 32'd0);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
